// File: rtl/aes_pkg.sv
// Shared AES helpers: state encoding, GF(2^8) arithmetic, S-boxes, rcon and byte/word slicing.
// Used by both the encryption and decryption datapaths.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 by repeated squaring; 0 maps to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gmul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] a;
    a = gf_inv(x);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Byte 0 is the most significant byte of the block.
  function automatic logic [7:0] get_byte(input logic [127:0] blk, input int i);
    return blk[127-8*i -: 8];
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless skip_mix_i is set (last round).
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         skip_mix_i,
  output logic [127:0] st_o
);

  logic [127:0] shifted;
  logic [127:0] keyed;
  logic [127:0] mixed;

  always_comb begin
    shifted = '0;
    keyed   = '0;
    mixed   = '0;
    // Byte 4*c+r sits at row r, column c; row r rotates right by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127-8*(4*c+r) -: 8] = get_byte(st_i, 4*((c - r + 4) % 4) + r);
      end
    end
    for (int i = 0; i < 16; i++) begin
      keyed[127-8*i -: 8] = inv_sbox(get_byte(shifted, i)) ^ get_byte(rk_i, i);
    end
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 8]  = gmul(get_byte(keyed, 4*c), 8'h0e) ^ gmul(get_byte(keyed, 4*c+1), 8'h0b)
                            ^ gmul(get_byte(keyed, 4*c+2), 8'h0d) ^ gmul(get_byte(keyed, 4*c+3), 8'h09);
      mixed[119-32*c -: 8]  = gmul(get_byte(keyed, 4*c), 8'h09) ^ gmul(get_byte(keyed, 4*c+1), 8'h0e)
                            ^ gmul(get_byte(keyed, 4*c+2), 8'h0b) ^ gmul(get_byte(keyed, 4*c+3), 8'h0d);
      mixed[111-32*c -: 8]  = gmul(get_byte(keyed, 4*c), 8'h0d) ^ gmul(get_byte(keyed, 4*c+1), 8'h09)
                            ^ gmul(get_byte(keyed, 4*c+2), 8'h0e) ^ gmul(get_byte(keyed, 4*c+3), 8'h0b);
      mixed[103-32*c -: 8]  = gmul(get_byte(keyed, 4*c), 8'h0b) ^ gmul(get_byte(keyed, 4*c+1), 8'h0d)
                            ^ gmul(get_byte(keyed, 4*c+2), 8'h09) ^ gmul(get_byte(keyed, 4*c+3), 8'h0e);
    end
    st_o = skip_mix_i ? keyed : mixed;
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 decryption, one round per clock. Round keys are regenerated backward
// from k10, which is expanded forward or taken from a one-entry cache of the last key.
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         start,
  input  logic [127:0] datain,
  input  logic [127:0] keyin,
  output logic [127:0] dataout,
  output logic         busy,
  output logic         done,
  output aes_state_e   state_dbg
);

  // Handshake: start is sampled only in IDLE; busy rises on the accepted edge and stays
  // high through the single done cycle, in which dataout is valid and held until the next done.

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word(rot_word(w3)) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  aes_state_e   state_q, state_d;
  logic [127:0] st_q, st_d, kr_q, kr_d, key_q, key_d;
  logic [127:0] k10_cache_q, k10_cache_d, cache_key_q, cache_key_d;
  logic         cache_valid_q, cache_valid_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] dout_q, dout_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic [127:0] kfwd, kinv, round_out;
  logic         cache_hit;

  assign cache_hit = KEY_CACHE && cache_valid_q && (keyin == cache_key_q);
  assign kfwd      = key_fwd(kr_q, rcon(cnt_q));
  assign kinv      = key_inv(kr_q, rcon(cnt_q));

  aes_inv_round u_inv_round (
    .st_i       (st_q),
    .rk_i       (kr_q),
    .skip_mix_i (state_q == ST_FINAL),
    .st_o       (round_out)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = cache_hit ? ST_INIT : ST_KEYEXP;
      ST_KEYEXP: if (cnt_q == 4'd10) state_d = ST_INIT;
      ST_INIT:   state_d = ST_ROUND;
      ST_ROUND:  if (cnt_q == 4'd1) state_d = ST_FINAL;
      ST_FINAL:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // cnt always holds the rcon index of the key currently in kr, so INIT and ROUND share kinv.
  always_comb begin
    st_d          = st_q;
    kr_d          = kr_q;
    key_d         = key_q;
    cnt_d         = cnt_q;
    k10_cache_d   = k10_cache_q;
    cache_key_d   = cache_key_q;
    cache_valid_d = cache_valid_q;
    dout_d        = dout_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = start;
        if (start) begin
          st_d  = datain;
          key_d = keyin;
          if (cache_hit) begin
            kr_d  = k10_cache_q;
            cnt_d = 4'd10;
          end else begin
            kr_d  = keyin;
            cnt_d = 4'd1;
          end
        end
      end
      ST_KEYEXP: begin
        kr_d = kfwd;
        if (cnt_q == 4'd10) begin
          k10_cache_d   = kfwd;
          cache_key_d   = key_q;
          cache_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_INIT: begin
        st_d  = st_q ^ kr_q;
        kr_d  = kinv;
        cnt_d = 4'd9;
      end
      ST_ROUND: begin
        st_d  = round_out;
        kr_d  = kinv;
        cnt_d = cnt_q - 4'd1;
      end
      ST_FINAL: begin
        dout_d = round_out;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      st_q          <= '0;
      kr_q          <= '0;
      key_q         <= '0;
      cnt_q         <= '0;
      k10_cache_q   <= '0;
      cache_key_q   <= '0;
      cache_valid_q <= 1'b0;
      dout_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      st_q          <= st_d;
      kr_q          <= kr_d;
      key_q         <= key_d;
      cnt_q         <= cnt_d;
      k10_cache_q   <= k10_cache_d;
      cache_key_q   <= cache_key_d;
      cache_valid_q <= cache_valid_d;
      dout_q        <= dout_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign dataout   = dout_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
